// File: rtl/infifo_rd_scheduler.sv
// Purpose : read-side sequencer for the 16-bank input FIFO; walks RA over all
//           addresses once per resident frame and tags returned blocks.
// Latency : first rd_en one cycle after load_fsm_start; blk_valid trails rd_en
//           by RDLAT; frame_done NADDR+RDLAT+1 cycles after start at full rate.
// Backpr. : rd_en follows dn_ready in READ, RA holds while dn_ready is low, so
//           no address is skipped; one extra start is queued, further ones drop.
//
// Ports:
//   clk, rst        decoder clock, synchronous active-high reset
//   load_fsm_start  one-cycle pulse: a complete frame is in the FIFO
//   dn_ready        downstream accepts a block this cycle
//   RA, rd_en       FIFO read address / read enable
//   blk_valid       DOUT_nb carries a valid block this cycle
//   blk_index       FIFO address of that block, aligned with blk_valid
//   frame_done      one-cycle pulse after the last block of a frame
//   busy            scheduler not idle
//   ovf             sticky: a start was dropped (cleared only by rst)
//   frame_cnt       (INFIFO_FRAME_CNT_EN) completed frames, wraps at 16 bits
//   dropped_cnt     (INFIFO_FRAME_CNT_EN) dropped starts, saturates at 0xFF
//
// Optional feature macro: INFIFO_FRAME_CNT_EN adds frame_cnt and dropped_cnt.
// Parameter limits: 2**ADDRESSWIDTH >= NADDR, 2**IDXW >= NADDR, RDLAT in 1..3.

module infifo_rd_scheduler #(
  parameter int ADDRESSWIDTH = 5,
  parameter int NADDR        = 16,
  parameter int RDLAT        = 1,
  parameter int IDXW         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_fsm_start,
  input  logic                    dn_ready,
  output logic [ADDRESSWIDTH-1:0] RA,
  output logic                    rd_en,
  output logic                    blk_valid,
  output logic [IDXW-1:0]         blk_index,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    ovf
`ifdef INFIFO_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt,
  output logic [7:0]              dropped_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDRESSWIDTH-1:0] LAST_RA    = ADDRESSWIDTH'(NADDR - 1);
  localparam logic [1:0]              LAST_DRAIN = 2'(RDLAT - 1);

  state_t                  state, state_nxt;
  logic [ADDRESSWIDTH-1:0] ra_nxt;
  logic [1:0]              drain_cnt, drain_nxt;
  logic                    pending, pending_nxt;
  logic                    ovf_nxt;
  logic                    fd_nxt;
  logic                    consume;   // a queued start launches a frame this cycle
  logic                    drop;      // a start is lost this cycle

  // read-enable / index delay line, independent of the FSM state
  logic [RDLAT-1:0]        vld_sr;
  logic [IDXW-1:0]         idx_sr [RDLAT];

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    ra_nxt      = RA;
    drain_nxt   = drain_cnt;
    pending_nxt = pending;
    ovf_nxt     = ovf;
    fd_nxt      = 1'b0;
    consume     = 1'b0;
    drop        = 1'b0;
    rd_en       = 1'b0;

    unique case (state)
      IDLE: begin
        if (load_fsm_start || pending) begin
          state_nxt = READ;
          ra_nxt    = '0;
          consume   = pending;
        end
      end

      READ: begin
        rd_en = dn_ready;
        if (dn_ready) begin
          if (RA == LAST_RA) begin
            state_nxt = DRAIN;
            drain_nxt = '0;
          end else begin
            ra_nxt = RA + 1'b1;
          end
        end
      end

      DRAIN: begin
        // The last DRAIN cycle is exactly RDLAT cycles after the final rd_en,
        // which is when the final blk_valid appears on the delay line.
        if (drain_cnt == LAST_DRAIN) begin
          fd_nxt = 1'b1;
          if (pending) begin
            state_nxt = READ;
            ra_nxt    = '0;
            consume   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          drain_nxt = drain_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Pending slot: a start in IDLE launches directly; while busy it is queued
    // unless the slot is occupied and not being vacated this same cycle.
    if (state == IDLE) begin
      pending_nxt = pending && load_fsm_start;
    end else if (load_fsm_start) begin
      if (consume || !pending) begin
        pending_nxt = 1'b1;
      end else begin
        drop    = 1'b1;
        ovf_nxt = 1'b1;
      end
    end else if (consume) begin
      pending_nxt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      RA         <= '0;
      drain_cnt  <= '0;
      pending    <= 1'b0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      RA         <= ra_nxt;
      drain_cnt  <= drain_nxt;
      pending    <= pending_nxt;
      ovf        <= ovf_nxt;
      frame_done <= fd_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid / index pipeline matching the RAM read latency
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < RDLAT; i++) begin
        idx_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= rd_en;
      idx_sr[0] <= IDXW'(RA);
      for (int i = 1; i < RDLAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
    end
  end

  assign blk_valid = vld_sr[RDLAT-1];
  assign blk_index = idx_sr[RDLAT-1];
  assign busy      = (state != IDLE);

`ifdef INFIFO_FRAME_CNT_EN
  // ---------------------------------------------------------------------------
  // Frame / drop statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      dropped_cnt <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (drop && (dropped_cnt != 8'hFF)) begin
        dropped_cnt <= dropped_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
